// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: imem request/response, EX redirect and IF/ID handoff.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [WIDTH-1:0]   imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [WIDTH-1:0]   redirect_pc;
  logic               if_valid;
  logic               if_ready;
  logic [WIDTH-1:0]   if_pc;
  logic [INSTR_W-1:0] if_instr;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {pc, instr} entries with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  fetch_entry_t    data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output fetch_entry_t    head_o,
  output logic [CntW-1:0] count_o
);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign do_push = push_i && (count_q != CntW'(DEPTH)) && !flush_i;
  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem requests and
// buffers in-order responses for the IF/ID register; redirects flush everything.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      DEPTH    = 2
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);

  localparam int unsigned     CntW   = $clog2(DEPTH) + 1;
  localparam logic [CntW:0]   Credit = (CntW + 1)'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, redirect_tgt;
  logic [CntW-1:0]  outstanding_q, outstanding_d, drop_q, drop_d, fifo_count;
  logic [CntW:0]    inflight_total;
  logic             req_fire, rsp_keep, fifo_push, fifo_pop, head_valid;
  fetch_entry_t     push_entry, head_entry;
  logic             unused_redirect_lsb;

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
  assign redirect_tgt        = {bus.redirect_pc[WIDTH-1:2], 2'b00};

  // Credit counts both in-flight requests and buffered entries, so the FIFO cannot overflow.
  assign inflight_total      = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign bus.imem_req_valid  = rst_n && (inflight_total < Credit);
  assign bus.imem_req_addr   = pc_q;
  assign req_fire            = bus.imem_req_valid && bus.imem_req_ready;

  assign head_valid   = (fifo_count != '0);
  assign bus.if_valid = head_valid;
  assign bus.if_pc    = head_valid ? WIDTH'(head_entry.pc) : '0;
  assign bus.if_instr = head_valid ? head_entry.instr : '0;

  always_comb begin
    rsp_keep         = bus.imem_rsp_valid && (drop_q == '0) && !bus.redirect_valid;
    fifo_push        = rsp_keep;
    fifo_pop         = head_valid && bus.if_ready && !bus.redirect_valid;
    push_entry.pc    = XLEN'(rsp_pc_q);
    push_entry.instr = bus.imem_rsp_data;
    outstanding_d    = outstanding_q + CntW'(req_fire) - CntW'(bus.imem_rsp_valid);
    pc_d             = req_fire ? pc_q + WIDTH'(PC_STEP) : pc_q;
    // rsp_pc tracks the PC of the next response that will actually be kept.
    rsp_pc_d         = rsp_keep ? rsp_pc_q + WIDTH'(PC_STEP) : rsp_pc_q;
    drop_d           = (bus.imem_rsp_valid && (drop_q != '0)) ? drop_q - CntW'(1) : drop_q;
    if (bus.redirect_valid) begin
      pc_d     = redirect_tgt;
      rsp_pc_d = redirect_tgt;
      drop_d   = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .flush_i (bus.redirect_valid),
    .head_o  (head_entry),
    .count_o (fifo_count)
  );

  rsp_without_req_a: assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_rsp_valid |-> (outstanding_q != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomised checks of fetch_unit against an in-order imem model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_hi_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.WIDTH(32)) bus ();
  fetch_if #(.WIDTH(32)) bus_hi ();

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_hi (
    .clk   (clk),
    .rst_n (rst_hi_n),
    .bus   (bus_hi)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat_cfg = 1;
  bit lat_rand = 1'b0;
  int lat_now;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  int          pop_cyc[$];

  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        hi_rsp_valid = 1'b0;
  logic [31:0] hi_rsp_data = '0;
  logic        hi_hs;
  logic [31:0] hi_addr;

  assign bus.imem_rsp_valid    = mem_rsp_valid;
  assign bus.imem_rsp_data     = mem_rsp_data;
  assign bus_hi.imem_rsp_valid = hi_rsp_valid;
  assign bus_hi.imem_rsp_data  = hi_rsp_data;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Main imem model plus request/pop logging; responses are driven 1 time unit after the edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem_q.delete();
    end else begin
      if (bus.imem_rsp_valid) void'(mem_q.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        lat_now = lat_rand ? int'($urandom_range(1, 5)) : lat_cfg;
        mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat_now});
        req_log.push_back(bus.imem_req_addr);
        req_cyc.push_back(cyc);
      end
      if (bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
        pop_pc.push_back(bus.if_pc);
        pop_instr.push_back(bus.if_instr);
        pop_cyc.push_back(cyc);
      end
    end
    cyc++;
    #1;
    if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(mem_q[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  end

  // Second instance: always-ready memory with latency 1.
  always @(posedge clk) begin
    hi_hs   = rst_hi_n && bus_hi.imem_req_valid && bus_hi.imem_req_ready;
    hi_addr = bus_hi.imem_req_addr;
    #1;
    hi_rsp_valid = hi_hs && rst_hi_n;
    hi_rsp_data  = instr_of(hi_addr);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    pop_pc.delete();
    pop_instr.delete();
    pop_cyc.delete();
  endtask

  task automatic do_reset(input bit rdy);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = rdy;
    step(2);
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step(2);
    n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
    n_tests++; if (bus.if_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_if_valid: got %b expected 0", bus.if_valid); end
    n_tests++; if (bus.if_pc !== 32'h0) begin n_fail++;
      $display("FAIL reset_if_pc: got %h expected 0", bus.if_pc); end
    n_tests++; if (bus.if_instr !== 32'h0) begin n_fail++;
      $display("FAIL reset_if_instr: got %h expected 0", bus.if_instr); end
    clear_logs();
    rst_n = 1'b1;
    #1;
    n_tests++; if (bus.imem_req_valid !== 1'b1) begin n_fail++;
      $display("FAIL reset_first_req_valid: got %b expected 1", bus.imem_req_valid); end
    n_tests++; if (bus.imem_req_addr !== 32'h0) begin n_fail++;
      $display("FAIL reset_first_addr: got %h expected 0", bus.imem_req_addr); end
  endtask

  task automatic test_stream();
    lat_cfg = 1;
    do_reset(1'b1);
    step(20);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (req_log.size() <= i || req_log[i] !== 32'(4 * i)) begin n_fail++;
        $display("FAIL stream_addr[%0d]: got %h expected %h", i,
                 (req_log.size() > i) ? req_log[i] : 32'hx, 32'(4 * i)); end
    end
    n_tests++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 32'h0 || pop_instr[0] !== instr_of(32'h0)) begin
      n_fail++;
      $display("FAIL stream_first_pop: got pc %h instr %h expected pc 0 instr %h",
               (pop_pc.size() > 0) ? pop_pc[0] : 32'hx,
               (pop_pc.size() > 0) ? pop_instr[0] : 32'hx, instr_of(32'h0)); end
    n_tests++;
    if (pop_cyc.size() == 0 || req_cyc.size() == 0 || pop_cyc[0] - req_cyc[0] != 2) begin
      n_fail++;
      $display("FAIL stream_first_latency: got %0d expected 2",
               (pop_cyc.size() > 0 && req_cyc.size() > 0) ? pop_cyc[0] - req_cyc[0] : -1); end
  endtask

  task automatic test_stall();
    lat_cfg = 1;
    do_reset(1'b0);
    step(10);
    n_tests++; if (req_log.size() != 2) begin n_fail++;
      $display("FAIL stall_req_count: got %0d expected 2", req_log.size()); end
    n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL stall_req_valid: got %b expected 0", bus.imem_req_valid); end
    n_tests++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin n_fail++;
      $display("FAIL stall_head: got valid %b pc %h expected valid 1 pc 0",
               bus.if_valid, bus.if_pc); end
    n_tests++; if (bus.if_instr !== instr_of(32'h0)) begin n_fail++;
      $display("FAIL stall_head_instr: got %h expected %h", bus.if_instr, instr_of(32'h0)); end
    bus.if_ready = 1'b1;
    step(12);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (pop_pc.size() <= i || pop_pc[i] !== 32'(4 * i) || pop_instr[i] !== instr_of(32'(4 * i)))
      begin n_fail++;
        $display("FAIL stall_resume[%0d]: got pc %h expected pc %h", i,
                 (pop_pc.size() > i) ? pop_pc[i] : 32'hx, 32'(4 * i)); end
    end
    n_tests++; if (pop_cyc.size() < 2 || pop_cyc[1] != pop_cyc[0] + 1) begin n_fail++;
      $display("FAIL stall_buffered_pair: got gap %0d expected 1",
               (pop_cyc.size() >= 2) ? pop_cyc[1] - pop_cyc[0] : -1); end
  endtask

  task automatic test_redirect_inflight();
    lat_cfg = 3;
    do_reset(1'b1);
    step(2);
    n_tests++; if (req_log.size() != 2 || bus.imem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL rdr_inflight_setup: got reqs %0d valid %b expected 2 and 0",
               req_log.size(), bus.imem_req_valid); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_1002;
    step(1);
    bus.redirect_valid = 1'b0;
    n_tests++; if (bus.imem_req_addr !== 32'h0000_1000) begin n_fail++;
      $display("FAIL rdr_inflight_addr: got %h expected 00001000", bus.imem_req_addr); end
    step(15);
    n_tests++; if (req_log.size() < 3 || req_log[2] !== 32'h0000_1000) begin n_fail++;
      $display("FAIL rdr_inflight_req: got %h expected 00001000",
               (req_log.size() > 2) ? req_log[2] : 32'hx); end
    n_tests++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 32'h0000_1000 ||
        pop_instr[0] !== instr_of(32'h0000_1000)) begin n_fail++;
      $display("FAIL rdr_inflight_first: got pc %h expected 00001000",
               (pop_pc.size() > 0) ? pop_pc[0] : 32'hx); end
    n_tests++; if (pop_pc.size() < 2 || pop_pc[1] !== 32'h0000_1004) begin n_fail++;
      $display("FAIL rdr_inflight_second: got pc %h expected 00001004",
               (pop_pc.size() > 1) ? pop_pc[1] : 32'hx); end
    lat_cfg = 1;
  endtask

  task automatic test_redirect_collide();
    lat_cfg = 1;
    do_reset(1'b1);
    step(1);
    n_tests++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h4 || bus.imem_rsp_valid !== 1'b1)
    begin n_fail++;
      $display("FAIL collide_setup: got valid %b addr %h rsp %b expected 1 4 1",
               bus.imem_req_valid, bus.imem_req_addr, bus.imem_rsp_valid); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_2000;
    step(1);
    bus.redirect_valid = 1'b0;
    n_tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL collide_new_req: got valid %b addr %h expected 1 00002000",
               bus.imem_req_valid, bus.imem_req_addr); end
    step(12);
    n_tests++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 32'h0000_2000 ||
        pop_instr[0] !== instr_of(32'h0000_2000)) begin n_fail++;
      $display("FAIL collide_first: got pc %h expected 00002000",
               (pop_pc.size() > 0) ? pop_pc[0] : 32'hx); end
    n_tests++; if (pop_pc.size() < 2 || pop_pc[1] !== 32'h0000_2004) begin n_fail++;
      $display("FAIL collide_second: got pc %h expected 00002004",
               (pop_pc.size() > 1) ? pop_pc[1] : 32'hx); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, tgt, prev_addr;
    logic        rdr, prev_pend;
    int          n_pop;
    do_reset(1'b1);
    lat_rand  = 1'b1;
    exp_pc    = 32'h0;
    prev_pend = 1'b0;
    prev_addr = '0;
    n_pop     = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #2;
      rdr = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.if_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = rdr;
      bus.redirect_pc    = tgt;
      if (prev_pend) begin
        n_tests++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== prev_addr) begin n_fail++;
          $display("FAIL rand_hold: got valid %b addr %h expected 1 %h",
                   bus.imem_req_valid, bus.imem_req_addr, prev_addr); end
      end
      @(negedge clk);
      if (rdr) begin
        exp_pc = {tgt[31:2], 2'b00};
      end else if (bus.if_valid && bus.if_ready) begin
        n_tests++;
        if (bus.if_pc !== exp_pc || bus.if_instr !== instr_of(exp_pc)) begin n_fail++;
          $display("FAIL rand_pop: got pc %h instr %h expected pc %h instr %h",
                   bus.if_pc, bus.if_instr, exp_pc, instr_of(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        n_pop++;
      end
      prev_pend = bus.imem_req_valid && !bus.imem_req_ready && !rdr;
      prev_addr = bus.imem_req_addr;
    end
    @(posedge clk);
    #2;
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    lat_rand = 1'b0;
    n_tests++; if (n_pop < 60) begin n_fail++;
      $display("FAIL rand_progress: got %0d pops expected at least 60", n_pop); end
    step(10);
  endtask

  task automatic test_wrap_reset();
    logic [31:0] seen[$];
    logic [31:0] exp_wrap[3];
    exp_wrap[0] = 32'hFFFF_FFF8;
    exp_wrap[1] = 32'hFFFF_FFFC;
    exp_wrap[2] = 32'h0000_0000;
    step(1);
    n_tests++;
    if (bus_hi.imem_req_valid !== 1'b0 || bus_hi.if_valid !== 1'b0 ||
        bus_hi.if_pc !== 32'h0 || bus_hi.if_instr !== 32'h0) begin n_fail++;
      $display("FAIL hi_in_reset: got %b %b %h %h expected all 0", bus_hi.imem_req_valid,
               bus_hi.if_valid, bus_hi.if_pc, bus_hi.if_instr); end
    rst_hi_n = 1'b1;
    #1;
    n_tests++; if (bus_hi.imem_req_valid !== 1'b1 || bus_hi.imem_req_addr !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL hi_first_req: got valid %b addr %h expected 1 fffffff8",
               bus_hi.imem_req_valid, bus_hi.imem_req_addr); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_hi.if_valid) seen.push_back(bus_hi.if_pc);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (seen.size() <= i || seen[i] !== exp_wrap[i]) begin n_fail++;
        $display("FAIL hi_wrap[%0d]: got %h expected %h", i,
                 (seen.size() > i) ? seen[i] : 32'hx, exp_wrap[i]); end
    end
    @(posedge clk);
    #2;
    rst_hi_n = 1'b0;
    #1;
    n_tests++;
    if (bus_hi.imem_req_valid !== 1'b0 || bus_hi.if_valid !== 1'b0 ||
        bus_hi.if_pc !== 32'h0 || bus_hi.if_instr !== 32'h0) begin n_fail++;
      $display("FAIL hi_mid_reset: got %b %b %h %h expected all 0", bus_hi.imem_req_valid,
               bus_hi.if_valid, bus_hi.if_pc, bus_hi.if_instr); end
    step(2);
    rst_hi_n = 1'b1;
    #1;
    n_tests++; if (bus_hi.imem_req_valid !== 1'b1 || bus_hi.imem_req_addr !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL hi_restart_req: got valid %b addr %h expected 1 fffffff8",
               bus_hi.imem_req_valid, bus_hi.imem_req_addr); end
    seen.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_hi.if_valid) seen.push_back(bus_hi.if_pc);
    end
    n_tests++; if (seen.size() == 0 || seen[0] !== 32'hFFFF_FFF8) begin n_fail++;
      $display("FAIL hi_restart_pop: got %h expected fffffff8",
               (seen.size() > 0) ? seen[0] : 32'hx); end
  endtask

  initial begin
    bus.imem_req_ready    = 1'b1;
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = '0;
    bus.if_ready          = 1'b1;
    bus_hi.imem_req_ready = 1'b1;
    bus_hi.redirect_valid = 1'b0;
    bus_hi.redirect_pc    = '0;
    bus_hi.if_ready       = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_random();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
